bp_update_ctrl: RTL and testbench

//  Update/initialisation sequencer for the two-level branch predictor tables
//  (16x4b BHT, 128x2b PHT). Clears both tables after reset and queues resolved

---
 rtl/bp_update_ctrl.sv | 110 +++++++++++
 tb/tb_bp_update_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_update_ctrl.sv
// bp_update_ctrl: clears the BHT/PHT after reset, then applies queued resolved
// branches as BHR-shift + 2-bit saturating counter read-modify-writes.
module bp_update_ctrl #(
    parameter int         QDEPTH   = 4,
    parameter logic [1:0] PHT_INIT = 2'b00
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic        fe_lookup,
    output logic        init_done,
    output logic        busy,
    output logic [3:0]  bht_addr,
    output logic        bht_we,
    output logic [3:0]  bht_wdata,
    input  logic [3:0]  bht_rdata,
    output logic [6:0]  pht_addr,
    output logic        pht_we,
    output logic [1:0]  pht_wdata,
    input  logic [1:0]  pht_rdata
);
    localparam int AW = $clog2(QDEPTH);

    typedef enum logic [2:0] {INIT, IDLE, RD_BHT, RD_PHT, WR} state_t;

    state_t              state, state_nx;
    logic [6:0]          init_idx;
    logic [31:0]         q_pc [QDEPTH];
    logic [QDEPTH-1:0]   q_taken;
    logic [AW-1:0]       head, tail;
    logic [AW:0]         count;
    logic [3:0]          bhr;
    logic [1:0]          ctr;
    logic                push, pop, full;
    logic [31:0]         h_pc;
    logic                h_taken;

    function automatic logic [3:0] pc_hash(input logic [31:0] pc);
        logic [3:0] h;
        h = '0;
        for (int i = 0; i < 8; i++) h = h ^ pc[4*i +: 4];
        return h;
    endfunction

    assign h_pc      = q_pc[head];
    assign h_taken   = q_taken[head];
    assign full      = count == (AW+1)'(QDEPTH);
    assign init_done = state != INIT;
    assign upd_ready = init_done & ~full;
    assign push      = upd_valid & upd_ready;
    assign pop       = (state == WR) & ~fe_lookup;
    assign busy      = (state != IDLE) | (count != '0);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= INIT;
            init_idx <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            state <= state_nx;
            if (state == INIT) init_idx <= init_idx + 7'd1;
            if (push) begin
                q_pc[tail]    <= upd_pc;
                q_taken[tail] <= upd_taken;
                tail          <= tail + 1'b1;
            end
            if (pop) head <= head + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            // table read data is only trusted on cycles the front end leaves the ports alone
            if (state == RD_BHT && !fe_lookup) bhr <= bht_rdata;
            if (state == RD_PHT && !fe_lookup) ctr <= pht_rdata;
        end
    end

    always_comb begin
        state_nx  = state;
        bht_addr  = pc_hash(h_pc);
        bht_we    = 1'b0;
        bht_wdata = {bhr[2:0], h_taken};
        pht_addr  = {h_pc[2:0], bhr};
        pht_we    = 1'b0;
        pht_wdata = h_taken ? (ctr == 2'd3 ? 2'd3 : ctr + 2'd1)
                            : (ctr == 2'd0 ? 2'd0 : ctr - 2'd1);
        case (state)
            INIT: begin
                pht_addr  = init_idx;
                pht_we    = 1'b1;
                pht_wdata = PHT_INIT;
                bht_addr  = init_idx[3:0];
                bht_we    = init_idx < 7'd16;
                bht_wdata = '0;
                state_nx  = init_idx == 7'd127 ? IDLE : INIT;
            end
            IDLE:    state_nx = (count != '0 && !fe_lookup) ? RD_BHT : IDLE;
            RD_BHT:  state_nx = fe_lookup ? RD_BHT : RD_PHT;
            RD_PHT:  state_nx = fe_lookup ? RD_PHT : WR;
            WR: begin
                bht_we   = ~fe_lookup;
                pht_we   = ~fe_lookup;
                state_nx = fe_lookup ? WR : IDLE;
            end
            default: state_nx = INIT;
        endcase
    end
endmodule

// File: tb/tb_bp_update_ctrl.sv
// tb_bp_update_ctrl: bench with table memories and a queue/array model of the
// predictor update rules; directed scenarios followed by random traffic.
module tb_bp_update_ctrl;
    localparam int QDEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        upd_valid = 1'b0;
    logic        upd_ready;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic        fe_lookup = 1'b0;
    logic        init_done, busy;
    logic [3:0]  bht_addr, bht_wdata, bht_rdata;
    logic        bht_we, pht_we;
    logic [6:0]  pht_addr;
    logic [1:0]  pht_wdata, pht_rdata;

    bp_update_ctrl #(.QDEPTH(QDEPTH), .PHT_INIT(2'b00)) dut (
        .clk(clk), .resetn(resetn), .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_pc(upd_pc), .upd_taken(upd_taken), .fe_lookup(fe_lookup),
        .init_done(init_done), .busy(busy),
        .bht_addr(bht_addr), .bht_we(bht_we), .bht_wdata(bht_wdata), .bht_rdata(bht_rdata),
        .pht_addr(pht_addr), .pht_we(pht_we), .pht_wdata(pht_wdata), .pht_rdata(pht_rdata)
    );

    always #5 clk = ~clk;

    logic [3:0] bht_mem [16];
    logic [1:0] pht_mem [128];
    assign bht_rdata = bht_mem[bht_addr];
    assign pht_rdata = pht_mem[pht_addr];
    always @(posedge clk) begin
        if (bht_we) bht_mem[bht_addr] <= bht_wdata;
        if (pht_we) pht_mem[pht_addr] <= pht_wdata;
    end

    typedef struct { logic [31:0] pc; bit t; } upd_t;
    upd_t expq [$];
    int   mbht [16];
    int   mpht [128];
    int   mcount, nwrites, n_chk, n_err;
    bit   mon_en;
    upd_t m_u;
    int   m_h, m_b, m_i, m_c;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int hash_of(input logic [31:0] pc);
        int h = 0;
        for (int k = 0; k < 8; k++) h = h ^ int'((pc >> (4*k)) & 32'hF);
        return h;
    endfunction

    // scoreboard: every write pair must be the next queued update applied to the model tables
    always @(negedge clk) begin
        if (mon_en && resetn) begin
            check("ready", upd_ready, init_done && mcount < QDEPTH);
            if (init_done) begin
                if (fe_lookup) check("we_under_fe", {bht_we, pht_we}, 0);
                if (bht_we || pht_we) begin
                    if (expq.size() == 0) check("unexpected_write", 1, 0);
                    else begin
                        m_u = expq.pop_front();
                        m_h = hash_of(m_u.pc);
                        m_b = mbht[m_h];
                        m_i = (m_u.pc % 8) * 16 + m_b;
                        m_c = mpht[m_i];
                        m_c = m_u.t ? (m_c + 1 > 3 ? 3 : m_c + 1) : (m_c - 1 < 0 ? 0 : m_c - 1);
                        m_b = (m_b * 2 + int'(m_u.t)) % 16;
                        check("wr_bht_we", bht_we, 1);
                        check("wr_pht_we", pht_we, 1);
                        check("wr_bht_addr", bht_addr, m_h);
                        check("wr_bht_data", bht_wdata, m_b);
                        check("wr_pht_addr", pht_addr, m_i);
                        check("wr_pht_data", pht_wdata, m_c);
                        mbht[m_h] = m_b;
                        mpht[m_i] = m_c;
                        mcount--;
                        nwrites++;
                    end
                end
            end
            if (upd_valid && upd_ready) begin
                expq.push_back('{upd_pc, upd_taken});
                mcount++;
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic init_seq();
        for (int k = 0; k < 128; k++) begin
            @(negedge clk);
            check("init_done_low", init_done, 0);
            check("init_busy", busy, 1);
            check("init_ready", upd_ready, 0);
            check("init_pht_we", pht_we, 1);
            check("init_pht_addr", pht_addr, k);
            check("init_pht_data", pht_wdata, 0);
            check("init_bht_we", bht_we, k < 16);
            if (k < 16) check("init_bht_addr", bht_addr, k);
            if (k < 16) check("init_bht_data", bht_wdata, 0);
        end
        @(negedge clk);
        check("init_done_high", init_done, 1);
        check("idle_not_busy", busy, 0);
        for (int k = 0; k < 16; k++) check("bht_cleared", bht_mem[k], 0);
        for (int k = 0; k < 128; k++) check("pht_cleared", pht_mem[k], 0);
    endtask

    task automatic do_reset(input int n);
        resetn = 1'b0;
        expq.delete();
        mcount = 0;
        for (int k = 0; k < 16; k++) mbht[k] = 0;
        for (int k = 0; k < 128; k++) mpht[k] = 0;
        repeat (n) @(posedge clk);
        #1 resetn = 1'b1;
        mon_en = 1'b1;
        init_seq();
    endtask

    task automatic offer(input logic [31:0] pc, input bit t);
        bit got = 0;
        upd_valid = 1'b1;
        upd_pc = pc;
        upd_taken = t;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            got = upd_ready;
        end
        if (!got) check("offer_timeout", 0, 1);
        @(posedge clk);
        #1 upd_valid = 1'b0;
    endtask

    task automatic drain();
        bit idle = 0;
        fe_lookup = 1'b0;
        upd_valid = 1'b0;
        for (int k = 0; k < 300 && !idle; k++) begin
            @(negedge clk);
            idle = !busy;
        end
        check("drain_idle", idle, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc, w0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_init_done", init_done, 0);
        check("rst_busy", busy, 1);
        check("rst_ready", upd_ready, 0);
        check("rst_pht_we", pht_we, 1);
        check("rst_pht_addr", pht_addr, 0);
        check("rst_pht_data", pht_wdata, 0);
        check("rst_bht_we", bht_we, 1);
        check("rst_bht_addr", bht_addr, 0);
        check("rst_bht_data", bht_wdata, 0);
        sync();
        do_reset(1);

        sync();
        offer(32'h4, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check("lat_no_we", pht_we, 0);
        end
        @(negedge clk);
        check("lat_we", pht_we, 1);
        check("lat_bht_addr", bht_addr, 4);
        check("lat_pht_addr", pht_addr, 7'h40);
        drain();
        check("t2_pht40", pht_mem[7'h40], 1);
        check("t2_bht4", bht_mem[4], 1);

        sync();
        do_reset(1);
        sync();
        for (int k = 0; k < 8; k++) offer(32'h4, 1'b1);
        offer(32'h4, 1'b0);
        drain();
        check("t3_pht40", pht_mem[7'h40], 1);
        check("t3_pht47", pht_mem[7'h47], 1);
        check("t3_pht4f", pht_mem[7'h4F], 2);
        check("t3_bht4", bht_mem[4], 4'hE);

        sync();
        fe_lookup = 1'b1;
        offer(32'h123, 1'b1);
        repeat (10) begin
            @(negedge clk);
            check("hold_no_we", pht_we | bht_we, 0);
        end
        @(posedge clk);
        #1 fe_lookup = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("release_no_we", pht_we, 0);
        end
        @(negedge clk);
        check("release_we", pht_we, 1);
        drain();

        sync();
        w0 = nwrites;
        fe_lookup = 1'b1;
        upd_valid = 1'b1;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            upd_pc = 32'h1000 + 32'(k * 20);
            upd_taken = k[0];
            @(negedge clk);
            if (upd_ready) acc++;
            @(posedge clk);
            #1;
        end
        upd_valid = 1'b0;
        check("full_accept_count", acc, QDEPTH);
        @(negedge clk);
        check("full_not_ready", upd_ready, 0);
        @(posedge clk);
        #1 fe_lookup = 1'b0;
        drain();
        check("full_writes", nwrites - w0, QDEPTH);

        sync();
        for (int k = 0; k < 3000; k++) begin
            upd_valid = $urandom_range(0, 1) == 1;
            upd_pc = ($urandom_range(0, 3) == 0) ? $urandom : (32'($urandom_range(0, 15)) << $urandom_range(0, 28));
            upd_taken = $urandom_range(0, 1) == 1;
            fe_lookup = $urandom_range(0, 3) == 0;
            @(posedge clk);
            #1;
        end
        drain();
        check("rand_queue_empty", expq.size(), 0);
        for (int k = 0; k < 16; k++) check("rand_bht", bht_mem[k], mbht[k]);
        for (int k = 0; k < 128; k++) check("rand_pht", pht_mem[k], mpht[k]);

        sync();
        offer(32'h55, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rd_pht_no_we", pht_we, 0);
        #1 do_reset(1);
        repeat (20) @(negedge clk);
        check("post_reset_no_write", pht_mem[{3'b101, 4'h0}], 0);
        check("post_reset_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
